// File: rtl/button_bit_entry_if.sv
// rtl/button_bit_entry_if.sv - button entry signal bundle; history field present with BIT_ENTRY_HISTORY_EN.
interface button_bit_entry_if;
  logic       btn_one;
  logic       btn_zero;
  logic       bit_valid;
  logic       bit_val;
  logic       busy;
`ifdef BIT_ENTRY_HISTORY_EN
  logic [3:0] history;

  modport master (output btn_one, output btn_zero,
                  input bit_valid, input bit_val, input busy, input history);
  modport slave  (input btn_one, input btn_zero,
                  output bit_valid, output bit_val, output busy, output history);
`else
  modport master (output btn_one, output btn_zero,
                  input bit_valid, input bit_val, input busy);
  modport slave  (input btn_one, input btn_zero,
                  output bit_valid, output bit_val, output busy);
`endif
endinterface

// File: rtl/button_bit_entry.sv
// rtl/button_bit_entry.sv - two-button synchronize/debounce/arbitrate into one bit strobe per press.
// Optional 4-bit entry history register compiled in with BIT_ENTRY_HISTORY_EN.
module button_bit_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  button_bit_entry_if.slave bus
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EMIT     = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit 1 carries the "one" button, bit 0 the "zero" button.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db;
  logic [CNT_W-1:0] r_cnt [2];

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_next_val;
  logic       r_bit_valid;
  logic       r_bit_val;
  logic       r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_db    <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {bus.btn_one, bus.btn_zero};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_ONE;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_next_val = r_bit_val;
    case (r_state)
      S_IDLE: begin
        if (r_db[1] && r_db[0]) begin
          w_next = S_WAIT_REL;
        end else if (r_db[1] || r_db[0]) begin
          w_next     = S_EMIT;
          w_next_val = r_db[1];
        end
      end
      S_EMIT:     w_next = S_WAIT_REL;
      S_WAIT_REL: if (r_db == 2'b00) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bit_valid <= 1'b0;
      r_bit_val   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_bit_valid <= (w_next == S_EMIT);
      r_bit_val   <= w_next_val;
      r_busy      <= (w_next != S_IDLE);
    end
  end

  assign bus.bit_valid = r_bit_valid;
  assign bus.bit_val   = r_bit_val;
  assign bus.busy      = r_busy;

`ifdef BIT_ENTRY_HISTORY_EN
  logic [3:0] r_history;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_history <= 4'b0000;
    end else if (w_next == S_EMIT) begin
      r_history <= {r_history[2:0], w_next_val};
    end
  end

  assign bus.history = r_history;
`endif
endmodule

// File: tb/tb_button_bit_entry.sv
// tb/tb_button_bit_entry.sv - directed bench for button_bit_entry with a per-cycle behavioural model.
module tb_button_bit_entry;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  button_bit_entry_if bus ();

  button_bit_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a level flips after DB consecutive disagreeing samples of the twice-delayed
  // button; a press is accepted only when armed (both released since last accept).
  logic [1:0] m_s1, m_s2, m_db;
  int         m_run [2];
  logic       m_armed, m_valid, m_bitval;
  logic [3:0] m_hist;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_db = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_armed = 1'b1; m_valid = 1'b0; m_bitval = 1'b0; m_hist = 4'b0000;
    end else begin
      logic v;
      v = 1'b0;
      if (m_valid) begin
        // the strobe cycle always hands over to waiting for release
      end else if (m_armed) begin
        if (m_db[1] ^ m_db[0]) begin
          v = 1'b1; m_bitval = m_db[1]; m_armed = 1'b0;
          m_hist = {m_hist[2:0], m_db[1]};
        end else if (m_db[1] && m_db[0]) begin
          m_armed = 1'b0;
        end
      end else if (m_db == 2'b00) begin
        m_armed = 1'b1;
      end
      m_valid = v;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_db[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {bus.btn_one, bus.btn_zero};
    end
  end

  logic strobes [$];
  int   strobe_cyc    = -1;
  int   last_busy_cyc = -1;

  always @(negedge clk) begin
    n_checks++;
    if ({bus.bit_valid, bus.bit_val, bus.busy} !== {m_valid, m_bitval, ~m_armed}) begin
      n_fail++;
      $display("FAIL model_cmp cyc=%0d: got valid/val/busy=%b%b%b expected %b%b%b",
               cyc, bus.bit_valid, bus.bit_val, bus.busy, m_valid, m_bitval, ~m_armed);
    end
`ifdef BIT_ENTRY_HISTORY_EN
    n_checks++;
    if (bus.history !== m_hist) begin
      n_fail++;
      $display("FAIL model_hist cyc=%0d: got %b expected %b", cyc, bus.history, m_hist);
    end
`endif
    if (bus.bit_valid === 1'b1) begin
      strobes.push_back(bus.bit_val);
      strobe_cyc = cyc;
    end
    if (bus.busy === 1'b1) last_busy_cyc = cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic one, input int hold);
    @(negedge clk);
    if (one) bus.btn_one = 1'b1; else bus.btn_zero = 1'b1;
    wait_cycles(hold);
    bus.btn_one  = 1'b0;
    bus.btn_zero = 1'b0;
    wait_cycles(15);
  endtask

  initial begin
    int p, r, base;
    bus.btn_one  = 1'b0;
    bus.btn_zero = 1'b0;

    // reset and idle
    wait_cycles(3);
    check("reset_valid", int'(bus.bit_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    rst = 1'b1;
    wait_cycles(50);
    check("idle_no_strobe", strobes.size(), 0);
    check("idle_busy", int'(bus.busy), 0);

    // clean 1 press
    @(negedge clk);
    p = cyc;
    bus.btn_one = 1'b1;
    wait_cycles(20);
    r = cyc;
    bus.btn_one = 1'b0;
    wait_cycles(15);
    check("clean_count", strobes.size(), 1);
    check("clean_val", int'(strobes[0]), 1);
    check("clean_latency", strobe_cyc, p + 7);
    check("clean_busy_end", last_busy_cyc, r + 6);

    // bounce rejection then a real 0 press
    base = strobes.size();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); bus.btn_zero = 1'b1;
      wait_cycles(1);
      @(negedge clk); bus.btn_zero = 1'b0;
      wait_cycles(1);
    end
    wait_cycles(15);
    check("bounce_no_strobe", strobes.size() - base, 0);
    press(1'b0, 10);
    check("bounce_then_hold_count", strobes.size() - base, 1);
    check("bounce_then_hold_val", int'(strobes[base]), 0);

    // overlap: simultaneous press
    base = strobes.size();
    @(negedge clk);
    bus.btn_one = 1'b1; bus.btn_zero = 1'b1;
    wait_cycles(15);
    bus.btn_one = 1'b0; bus.btn_zero = 1'b0;
    wait_cycles(15);
    check("overlap_same_edge", strobes.size() - base, 0);

    // overlap: hold one, then add zero
    @(negedge clk);
    bus.btn_one = 1'b1;
    wait_cycles(2);
    bus.btn_zero = 1'b1;
    wait_cycles(15);
    bus.btn_one = 1'b0; bus.btn_zero = 1'b0;
    wait_cycles(15);
    check("overlap_held_count", strobes.size() - base, 1);
    check("overlap_held_val", int'(strobes[base]), 1);
    press(1'b0, 12);
    check("overlap_after_count", strobes.size() - base, 2);
    check("overlap_after_val", int'(strobes[base + 1]), 0);

    // reset while held in WAIT_REL
    base = strobes.size();
    @(negedge clk);
    bus.btn_one = 1'b1;
    wait_cycles(12);
    check("mid_busy_before", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.bit_valid), 0);
    check("mid_rst_val", int'(bus.bit_val), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    p = cyc;
    rst = 1'b1;
    wait_cycles(12);
    bus.btn_one = 1'b0;
    wait_cycles(15);
    check("mid_count", strobes.size() - base, 2);
    check("mid_val", int'(strobes[base + 1]), 1);
    check("mid_latency", strobe_cyc, p + 7);

    // sequence 1,1,0,1
    base = strobes.size();
    press(1'b1, 12);
    press(1'b1, 12);
    press(1'b0, 12);
    press(1'b1, 12);
    check("seq_count", strobes.size() - base, 4);
    if (strobes.size() - base == 4) begin
      check("seq_bits", int'({strobes[base], strobes[base + 1], strobes[base + 2], strobes[base + 3]}), 13);
    end
`ifdef BIT_ENTRY_HISTORY_EN
    check("seq_history", int'(bus.history), 13);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
